// File: rtl/filter2d_pkg.sv
// Types and counter-width helpers for the 2-D filter line-buffer stage.
package filter2d_pkg;
    import functions_pkg::*;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN,
        FLUSH
    } state_t;

    function automatic int unsigned row_width(input int unsigned frame_h);
        return clog2(frame_h - 1) + 1;
    endfunction

    function automatic int unsigned col_width(input int unsigned frame_w);
        return clog2(frame_w - 1) + 1;
    endfunction

endpackage

// File: rtl/functions_pkg.sv
// Shared constant-evaluation helpers.
package functions_pkg;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned n;
        v = (value > 0) ? value - 1 : 0;
        n = 0;
        while (v > 0) begin
            n++;
            v = v >> 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/filter2d_line_mem.sv
// Simple dual-port RAM with registered read; the array itself is never reset.
module filter2d_line_mem
    import filter2d_pkg::*;
#(
    parameter int unsigned DEPTH = 1920,
    parameter int unsigned WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         wr_en,
    input  logic [col_width(DEPTH)-1:0]  wr_addr,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    input  logic [col_width(DEPTH)-1:0]  rd_addr,
    output logic [WIDTH-1:0]             rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/filter2d_line_buf.sv
// Line buffer feeding the 2-D window generator: turns a raster stream into
// WIN_SIZE-tall columns (din[0] newest row) and flushes WIN_R zero rows at frame end.
module filter2d_line_buf
    import filter2d_pkg::*;
#(
    parameter int unsigned FRAME_H   = 1080,
    parameter int unsigned FRAME_W   = 1920,
    parameter int unsigned DIN_WIDTH = 8,
    parameter int unsigned WIN_SIZE  = 3
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                s_vld,
    input  logic                                s_sof,
    input  logic [DIN_WIDTH-1:0]                s_data,
    output logic                                s_rdy,
    output logic                                frame_start,
    output logic                                din_vld,
    output logic [WIN_SIZE-1:0][DIN_WIDTH-1:0]  din
);

    localparam int unsigned WIN_R = WIN_SIZE / 2;
    localparam int unsigned ROW_W = row_width(FRAME_H);
    localparam int unsigned COL_W = col_width(FRAME_W);
    localparam int unsigned MEM_W = (WIN_SIZE - 1) * DIN_WIDTH;

    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(FRAME_H - 1);
    localparam logic [ROW_W-1:0] PRIME_LAST = ROW_W'(WIN_R - 1);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(FRAME_W - 1);

    state_t               state;
    logic [ROW_W-1:0]     row;
    logic [COL_W-1:0]     col;
    logic [ROW_W-1:0]     row_next;
    logic [COL_W-1:0]     col_next;
    logic                 col_wrap;

    logic                 accept;
    logic                 restart;
    logic                 take;
    logic                 emit;
    logic [COL_W-1:0]     pix_col;
    logic [DIN_WIDTH-1:0] pix_data;

    logic                 held_vld;
    logic [COL_W-1:0]     held_col;
    logic [DIN_WIDTH-1:0] held_data;
    logic [MEM_W-1:0]     word;
    logic [MEM_W-1:0]     wr_word;

    always_comb begin
        accept   = s_vld && s_rdy;
        restart  = accept && s_sof;
        take     = restart || (accept && (state == PRIME || state == RUN)) || (state == FLUSH);
        emit     = !restart && (state == RUN || state == FLUSH);
        pix_col  = restart ? '0 : col;
        pix_data = (state == FLUSH) ? '0 : s_data;
        col_wrap = (col == COL_LAST);
        col_next = col_wrap ? '0 : col + COL_W'(1);
        row_next = col_wrap ? row + ROW_W'(1) : row;
        // Shift the column up one row: newest pixel enters the bottom, oldest row drops out.
        wr_word  = {word[MEM_W-DIN_WIDTH-1:0], held_data};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            row         <= '0;
            col         <= '0;
            s_rdy       <= 1'b0;
            frame_start <= 1'b0;
            din_vld     <= 1'b0;
            held_vld    <= 1'b0;
            held_col    <= '0;
            held_data   <= '0;
        end else begin
            frame_start <= restart;
            held_vld    <= take;
            din_vld     <= take && emit;
            if (take) begin
                held_col  <= pix_col;
                held_data <= pix_data;
            end

            // An accepted s_sof restarts the frame from any state that can accept.
            if (restart) begin
                state <= PRIME;
                row   <= '0;
                col   <= COL_W'(1);
                s_rdy <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        s_rdy <= 1'b1;
                    end
                    PRIME: begin
                        if (accept) begin
                            row <= row_next;
                            col <= col_next;
                            if (col_wrap && row == PRIME_LAST) begin
                                state <= RUN;
                            end
                        end
                    end
                    RUN: begin
                        if (accept) begin
                            if (col_wrap && row == ROW_LAST) begin
                                state <= FLUSH;
                                row   <= '0;
                                col   <= '0;
                                s_rdy <= 1'b0;
                            end else begin
                                row <= row_next;
                                col <= col_next;
                            end
                        end
                    end
                    FLUSH: begin
                        // Row/col counters are reused to count WIN_R injected rows.
                        if (col_wrap && row == PRIME_LAST) begin
                            state <= IDLE;
                            row   <= '0;
                            col   <= '0;
                            s_rdy <= 1'b1;
                        end else begin
                            row <= row_next;
                            col <= col_next;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign din = {word, held_data};

    filter2d_line_mem #(
        .DEPTH (FRAME_W),
        .WIDTH (MEM_W)
    ) u_line_mem (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (held_vld),
        .wr_addr (held_col),
        .wr_data (wr_word),
        .rd_en   (take),
        .rd_addr (pix_col),
        .rd_data (word)
    );

endmodule
